// File: rtl/conv_window_fetch.sv
// conv_window_fetch
//   Read-side sequencer for the ping-pong feature buffer. When the buffer
//   reports a full bank, walks every K x K x CH convolution window of the
//   IMG_H x IMG_W tile (kx innermost, then ky, c, ox, oy), drives read
//   addresses to the buffer and streams the returned bytes to the PE array
//   through a 2-entry output FIFO with valid/ready handshake. At the end of
//   the tile the ping-pong select is flipped to release the bank.
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_buf_ready          buffer has a full readable bank
//   o_conv_addr          registered read address to the buffer
//   i_conv_dout          buffer read data, one cycle after its address
//   o_switch_pingpong    bank-select level, toggles once per consumed tile
//   o_tap_data/_vld      tap byte to the PE and its valid
//   i_tap_rdy            PE accepts the tap when vld & rdy
//   o_tap_last           last tap of the current window (qualified by vld)
//   o_frame_last         last tap of the tile (qualified by vld)
//   o_busy               high whenever the sequencer is not idle
module conv_window_fetch #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int CH     = 3,
    parameter int K      = 3,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_buf_ready,
    output logic [ADDR_W-1:0] o_conv_addr,
    input  logic [DATA_W-1:0] i_conv_dout,
    output logic              o_switch_pingpong,
    output logic [DATA_W-1:0] o_tap_data,
    output logic              o_tap_vld,
    input  logic              i_tap_rdy,
    output logic              o_tap_last,
    output logic              o_frame_last,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] K_MAX  = ADDR_W'(K - 1);
    localparam logic [ADDR_W-1:0] CH_MAX = ADDR_W'(CH - 1);
    localparam logic [ADDR_W-1:0] OX_MAX = ADDR_W'(IMG_W - K);
    localparam logic [ADDR_W-1:0] OY_MAX = ADDR_W'(IMG_H - K);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_SWAP} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              frame;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, c_q, c_d, ox_q, ox_d, oy_q, oy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;   // read issued last cycle, data arrives now
    logic [1:0]        tag_q, tag_d;             // {last, frame} of the in-flight read
    logic [1:0]        count_q, count_d;
    entry_t            ent0_q, ent0_d, ent1_q, ent1_d;
    logic              pp_q, pp_d;
    logic              hold_q, hold_d;           // ignore i_buf_ready right after SWAP

    entry_t            in_ent;
    logic              pop, issue, tap_last, tap_frame;
    logic [2:0]        occ;

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] kx,
                                                   input logic [ADDR_W-1:0] ky,
                                                   input logic [ADDR_W-1:0] c,
                                                   input logic [ADDR_W-1:0] ox,
                                                   input logic [ADDR_W-1:0] oy);
        int a;
        a = int'(c) * IMG_W * IMG_H + (int'(oy) + int'(ky)) * IMG_W + int'(ox) + int'(kx);
        return ADDR_W'(a);
    endfunction

    assign in_ent = '{data: i_conv_dout, last: tag_q[1], frame: tag_q[0]};

    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        c_d        = c_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        addr_d     = addr_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        count_d    = count_q;
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        pp_d       = pp_q;
        hold_d     = hold_q;

        pop       = (count_q != 2'd0) && i_tap_rdy;
        occ       = {1'b0, count_q} + {2'b00, inflight_q};
        tap_last  = (kx_q == K_MAX) && (ky_q == K_MAX) && (c_q == CH_MAX);
        tap_frame = tap_last && (ox_q == OX_MAX) && (oy_q == OY_MAX);
        // Credit: FIFO entries plus the returning read, minus this cycle's pop,
        // must leave room for the read issued now.
        issue     = (state_q == S_RUN) && (occ < (pop ? 3'd3 : 3'd2));

        case (state_q)
            S_IDLE: begin
                hold_d = 1'b0;
                if (i_buf_ready && !hold_q) state_d = S_RUN;
            end
            S_RUN: begin
                if (issue && tap_frame) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    state_d = S_SWAP;
                    pp_d    = ~pp_q;
                end
            end
            S_SWAP: begin
                state_d = S_IDLE;
                hold_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Window walk: counters advance only when the current address is issued,
        // so the address bus holds while stalled and wraps to zero after the tile.
        if (issue) begin
            inflight_d = 1'b1;
            tag_d      = {tap_last, tap_frame};
            if (kx_q != K_MAX) kx_d = kx_q + 1'b1;
            else begin
                kx_d = '0;
                if (ky_q != K_MAX) ky_d = ky_q + 1'b1;
                else begin
                    ky_d = '0;
                    if (c_q != CH_MAX) c_d = c_q + 1'b1;
                    else begin
                        c_d = '0;
                        if (ox_q != OX_MAX) ox_d = ox_q + 1'b1;
                        else begin
                            ox_d = '0;
                            if (oy_q != OY_MAX) oy_d = oy_q + 1'b1;
                            else oy_d = '0;
                        end
                    end
                end
            end
            addr_d = tap_addr(kx_d, ky_d, c_d, ox_d, oy_d);
        end

        // Two-entry FIFO, entry 0 is the head presented to the PE.
        case (count_q)
            2'd0: begin
                if (inflight_q) begin
                    ent0_d  = in_ent;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (inflight_q && pop) ent0_d = in_ent;
                else if (inflight_q) begin
                    ent1_d  = in_ent;
                    count_d = 2'd2;
                end else if (pop) count_d = 2'd0;
            end
            default: begin
                if (pop) begin
                    ent0_d = ent1_q;
                    if (inflight_q) ent1_d = in_ent;
                    else count_d = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            c_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            ent0_q     <= '0;
            pp_q       <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            c_q        <= c_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            ent0_q     <= ent0_d;
            pp_q       <= pp_d;
            hold_q     <= hold_d;
        end
    end

    // Second FIFO slot and in-flight tags are only consumed when qualified
    // by count/inflight, so they carry no reset.
    always_ff @(posedge i_clk) begin
        ent1_q <= ent1_d;
        tag_q  <= tag_d;
    end

    assign o_conv_addr       = addr_q;
    assign o_switch_pingpong = pp_q;
    assign o_tap_vld         = (count_q != 2'd0);
    assign o_tap_data        = ent0_q.data;
    assign o_tap_last        = ent0_q.last;
    assign o_frame_last      = ent0_q.frame;
    assign o_busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_window_fetch.sv
// Testbench for conv_window_fetch: a buffer model returning mem[addr] one
// cycle later, a reference tap list built from the window traversal rules,
// a table of tile scenarios and hand-written reset / back-to-back sequences.
module tb_conv_window_fetch;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 16;
    localparam int CH     = 3;
    localparam int K      = 3;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int DEPTH  = IMG_W * IMG_H * CH;
    localparam int NWIN   = (IMG_W - K + 1) * (IMG_H - K + 1);
    localparam int NTAPS  = NWIN * K * K * CH;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_buf_ready;
    logic [ADDR_W-1:0] o_conv_addr;
    logic [DATA_W-1:0] dout;
    logic              o_switch_pingpong;
    logic [DATA_W-1:0] o_tap_data;
    logic              o_tap_vld;
    logic              i_tap_rdy;
    logic              o_tap_last;
    logic              o_frame_last;
    logic              o_busy;

    always #5 clk = ~clk;

    conv_window_fetch #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .K(K), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_buf_ready      (i_buf_ready),
        .o_conv_addr      (o_conv_addr),
        .i_conv_dout      (dout),
        .o_switch_pingpong(o_switch_pingpong),
        .o_tap_data       (o_tap_data),
        .o_tap_vld        (o_tap_vld),
        .i_tap_rdy        (i_tap_rdy),
        .o_tap_last       (o_tap_last),
        .o_frame_last     (o_frame_last),
        .o_busy           (o_busy)
    );

    // Buffer model: registered read, data valid one cycle after the address.
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        dout <= (int'(o_conv_addr) < DEPTH) ? mem[o_conv_addr] : 8'h00;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       frame;
    } tap_t;

    tap_t exp_tap  [NTAPS];
    int   exp_addr [NTAPS];

    int n_checks = 0;
    int n_fail   = 0;

    int r_taps, r_last, r_tog, r_swap, r_first, r_timeout;
    int addr_log [32];
    bit exp_pp = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic fill_mem(input bit pattern);
        for (int a = 0; a < DEPTH; a++)
            mem[a] = pattern ? 8'(a) : 8'($urandom);
    endtask

    // Reference traversal: plain nested loops over the window coordinates.
    task automatic build_expected();
        int i;
        int a;
        i = 0;
        for (int oy = 0; oy <= IMG_H - K; oy++)
            for (int ox = 0; ox <= IMG_W - K; ox++)
                for (int c = 0; c < CH; c++)
                    for (int ky = 0; ky < K; ky++)
                        for (int kx = 0; kx < K; kx++) begin
                            a = c * IMG_W * IMG_H + (oy + ky) * IMG_W + (ox + kx);
                            exp_addr[i]      = a;
                            exp_tap[i].data  = mem[a];
                            exp_tap[i].last  = (kx == K - 1) && (ky == K - 1) && (c == CH - 1);
                            exp_tap[i].frame = exp_tap[i].last && (ox == IMG_W - K) && (oy == IMG_H - K);
                            i++;
                        end
    endtask

    // Runs one tile from idle with i_buf_ready asserted; entered and left at a negedge.
    task automatic run_tile(input int pct, input int drop_at, input int rst_after, input int budget);
        int          cyc;
        bit          prev_stall;
        bit          rst_pend;
        bit          rst_done;
        bit [2:0]    qual;
        tap_t        prev_word;
        tap_t        cur;
        logic        prev_pp;
        logic [ADDR_W-1:0] prev_addr;
        cyc = 0; prev_stall = 0; rst_pend = 0; rst_done = 0; qual = '0; prev_word = '0;
        r_taps = 0; r_last = 0; r_tog = 0; r_swap = -1; r_first = -1; r_timeout = 0;
        prev_pp   = o_switch_pingpong;
        prev_addr = o_conv_addr;
        i_buf_ready = 1'b1;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                r_timeout = 1;
                break;
            end
            cur = '{data: o_tap_data, last: o_tap_last, frame: o_frame_last};
            if (cyc < 32) addr_log[cyc] = int'(o_conv_addr);
            if (rst_pend) begin
                i_rst = 1'b0;
                rst_pend = 0;
                check("rst_outputs", {o_conv_addr, o_switch_pingpong, o_tap_vld, o_tap_last,
                                      o_frame_last, o_tap_data, o_busy}, 0);
                r_taps = 0; r_last = 0; r_tog = 0; exp_pp = 1'b0; prev_pp = 1'b0;
            end else begin
                if (prev_stall) check("hold_stable", {o_tap_vld, cur}, {1'b1, prev_word});
                if (qual == 3'b111) check("addr_hold", o_conv_addr, prev_addr);
            end
            if (o_tap_vld && r_first < 0) r_first = cyc;
            if (o_switch_pingpong != prev_pp) begin
                r_tog++;
                if (r_swap < 0) r_swap = cyc;
                prev_pp = o_switch_pingpong;
            end
            if (r_tog >= 1 && !o_busy) break;
            if (drop_at >= 0 && r_taps >= drop_at) i_buf_ready = 1'b0;
            if (rst_after >= 0 && !rst_done && r_taps == rst_after) begin
                i_rst = 1'b1; i_tap_rdy = 1'b0;
                rst_pend = 1; rst_done = 1; prev_stall = 0; qual = '0;
            end else begin
                i_tap_rdy = ($urandom_range(0, 99) < pct);
                if (o_tap_vld && i_tap_rdy) begin
                    if (r_taps < NTAPS) check($sformatf("tap%0d", r_taps), cur, exp_tap[r_taps]);
                    else check("tap_overflow", r_taps + 1, NTAPS);
                    r_last += int'(o_tap_last);
                    r_taps++;
                end
                prev_stall = o_tap_vld && !i_tap_rdy;
                prev_word  = cur;
                qual = {qual[1:0], (!i_tap_rdy && o_busy)};
            end
            prev_addr = o_conv_addr;
        end
        if (r_timeout == 0) exp_pp = ~exp_pp;
    endtask

    typedef struct {
        int pct;
        bit pattern;
        int drop_at;
        int rst_after;
        int budget;
        int exp_swap;
        int exp_first;
        bit chk_addr;
    } row_t;

    row_t tbl [4];

    initial begin
        tbl[0] = '{100, 1'b1, -1,   -1,  8000, NTAPS + 4, 3, 1'b1};
        tbl[1] = '{30,  1'b0, -1,   -1, 25000, -1,        3, 1'b0};
        tbl[2] = '{70,  1'b0, 100,  -1, 12000, -1,        3, 1'b0};
        tbl[3] = '{100, 1'b0, -1, 1000,  8000, -1,        3, 1'b0};

        i_rst = 1'b1; i_buf_ready = 1'b0; i_tap_rdy = 1'b0;
        fill_mem(1'b1);
        repeat (2) @(negedge clk);
        check("reset_outputs", {o_conv_addr, o_switch_pingpong, o_tap_vld, o_tap_last,
                                o_frame_last, o_tap_data, o_busy}, 0);
        i_rst = 1'b0;
        @(negedge clk);
        check("idle_busy", o_busy, 0);

        for (int i = 0; i < 4; i++) begin
            fill_mem(tbl[i].pattern);
            build_expected();
            run_tile(tbl[i].pct, tbl[i].drop_at, tbl[i].rst_after, tbl[i].budget);
            i_buf_ready = 1'b0;
            check($sformatf("row%0d_timeout", i), r_timeout, 0);
            check($sformatf("row%0d_taps", i), r_taps, NTAPS);
            check($sformatf("row%0d_last_pulses", i), r_last, NWIN);
            check($sformatf("row%0d_toggles", i), r_tog, 1);
            check($sformatf("row%0d_pingpong", i), o_switch_pingpong, exp_pp);
            if (tbl[i].exp_swap >= 0) check($sformatf("row%0d_swap_cycle", i), r_swap, tbl[i].exp_swap);
            if (tbl[i].exp_first >= 0) check($sformatf("row%0d_first_vld", i), r_first, tbl[i].exp_first);
            if (tbl[i].chk_addr)
                for (int j = 0; j < K * K * CH; j++)
                    check($sformatf("row%0d_addr%0d", i, j), addr_log[j + 1], exp_addr[j]);
            @(negedge clk);
            check($sformatf("row%0d_idle_busy", i), o_busy, 0);
            check($sformatf("row%0d_idle_addr", i), o_conv_addr, 0);
        end

        // Back-to-back tiles with i_buf_ready held high: 0 -> 1 -> 0.
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        exp_pp = 1'b0;
        check("b2b_pp_reset", o_switch_pingpong, 0);
        fill_mem(1'b0);
        build_expected();
        run_tile(100, -1, -1, 8000);
        check("b2b1_timeout", r_timeout, 0);
        check("b2b1_taps", r_taps, NTAPS);
        check("b2b1_pp", o_switch_pingpong, 1);
        run_tile(100, -1, -1, 8000);
        i_buf_ready = 1'b0;
        check("b2b2_timeout", r_timeout, 0);
        check("b2b2_taps", r_taps, NTAPS);
        check("b2b2_pp", o_switch_pingpong, 0);
        check("b2b2_first_vld", r_first, 4);
        check("b2b2_start_addr", addr_log[2], 0);
        @(negedge clk);
        check("b2b_idle_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_window_fetch.md
# conv_window_fetch

Downstream read-side sequencer for the ping-pong feature buffer. Once the buffer reports a bank ready, it walks every K×K×CH convolution window of an IMG_H×IMG_W multi-channel tile, drives read addresses into the buffer, and streams the returned bytes to the PE array over a valid/ready handshake. At the end of a tile it flips the buffer's ping-pong select, releasing the consumed bank to the writer.

## Interface
- IMG_W, 16: tile width in pixels
- IMG_H, 16: tile height in pixels
- CH, 3: channel count; buffer depth is IMG_W*IMG_H*CH = 768
- K, 3: square kernel size
- ADDR_W, 10: buffer address width
- DATA_W, 8: pixel width
- i_clk  in  1  single clock; all logic rising-edge
- i_rst  in  1  synchronous, active-high reset
- i_buf_ready  in  1  buffer has a full bank readable (buffer's o_pl_buffer_ready)
- o_conv_addr  out  ADDR_W  read address to buffer (buffer's i_conv_addr)
- i_conv_dout  in  DATA_W  buffer read data, valid exactly one cycle after its address
- o_switch_pingpong  out  1  bank-select level to buffer; toggles once per consumed tile
- o_tap_data  out  DATA_W  tap byte to PE
- o_tap_vld  out  1  o_tap_data valid
- i_tap_rdy  in  1  PE accepts the tap this cycle when vld & rdy
- o_tap_last  out  1  with vld: last tap (tap 26) of the current window
- o_frame_last  out  1  with vld: last tap of the last window of the tile
- o_busy  out  1  high in any state other than IDLE

## Operation
- Address: addr = c*IMG_W*IMG_H + (oy+ky)*IMG_W + (ox+kx); unsigned, fits ADDR_W.
- Tap order (innermost first): kx 0..K-1, ky 0..K-1, c 0..CH-1, ox 0..IMG_W-K, oy 0..IMG_H-K. 27 taps per window, 14×14 = 196 windows, 5292 taps per tile.
- FSM states: IDLE, RUN, DRAIN, SWAP.
  - IDLE: counters zero; i_buf_ready=1 → RUN.
  - RUN: issue one address per cycle while credit allows; after issuing the final tap (addr 767) → DRAIN.
  - DRAIN: no issues; when FIFO empty and nothing in flight → SWAP.
  - SWAP: one cycle; o_switch_pingpong toggles on entry; → IDLE. IDLE ignores i_buf_ready in the cycle immediately after SWAP.
- Output buffer: 2-entry FIFO captures i_conv_dout together with its last/frame_last tags. An address may issue only when (fifo_count + inflight − pop) < 2, where inflight is the read issued in the previous cycle. The FIFO can never overflow and no read is ever dropped.
- o_tap_vld = FIFO non-empty; pop = vld & rdy. Data and tags hold stable while vld & !rdy.
- i_buf_ready dropping during RUN/DRAIN is ignored; the bank is owned until SWAP.
- Reset mid-operation returns to IDLE the next cycle, clears the FIFO, in-flight flag, and counters, and sets o_switch_pingpong to 0.

## Timing
- Reset values: o_conv_addr=0, o_switch_pingpong=0, o_tap_vld=0, o_tap_last=0, o_frame_last=0, o_tap_data=0, o_busy=0.
- o_conv_addr is registered. i_buf_ready seen at edge n puts RUN and addr 0 on the bus in cycle n+1. Data returns in n+2 and o_tap_vld rises in n+3.
- With i_tap_rdy held high, throughput is 1 tap/cycle with no bubbles.
- Minimum tile time: 5292 + 4 cycles from the i_buf_ready sample to SWAP.
- When i_tap_rdy is deasserted, at most 2 taps are buffered and address issue stalls within 1 cycle. The address bus holds its value while stalled.
- o_tap_last and o_frame_last are only meaningful while o_tap_vld=1.

## Test plan
- Reset, then i_buf_ready=1, rdy=1, with the buffer model returning data = addr[7:0] → first window addresses are 0,1,2,16,17,18,32,33,34,256,…,546. The tap at 546 has o_tap_last=1. First o_tap_vld occurs 3 cycles after the ready sample.
- Full tile with rdy=1 → 5292 taps and 196 o_tap_last pulses. The final tap is addr 767 with o_frame_last=1. o_switch_pingpong goes 0→1 exactly once, then the block returns to IDLE with o_busy=0.
- Random rdy at 30% high → the tap sequence is identical to the rdy=1 run. No duplicate or dropped taps. The FIFO never exceeds 2 entries. Data is stable while stalled.
- Two back-to-back tiles with i_buf_ready re-asserted → o_switch_pingpong toggles 0→1→0. The second tile starts at addr 0.
- i_rst=1 pulsed for one cycle mid-tile (after tap 1000) → all outputs take their reset values on the next cycle and o_switch_pingpong=0. With i_buf_ready=1 the tile restarts at addr 0.
- i_buf_ready deasserted during RUN → traversal continues uninterrupted to SWAP.
